// File: rtl/hazard1_lsu_pkg.sv
// rtl/hazard1_lsu_pkg.sv - shared AHB encodings, LSU state type and request decode helpers
package hazard1_lsu_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HSIZE_B = 2'b00;
  localparam logic [1:0] HSIZE_H = 2'b01;
  localparam logic [1:0] HSIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ADDR = 2'd1,
    LSU_DATA = 2'd2
  } lsu_state_e;

  // Size 3 does not exist on RV32; stores have no unsigned variant.
  function automatic logic funct3_illegal(input logic wr, input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (wr && f3[2]);
  endfunction

  function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == HSIZE_H) && a[0]) || ((size == HSIZE_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/hazard1_lsu_extend.sv
// rtl/hazard1_lsu_extend.sv - selects the load lane from hrdata and sign/zero-extends it
module hazard1_lsu_extend
  import hazard1_lsu_pkg::*;
(
  input  logic [31:0] hrdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = hrdata[7:0];
    case (addr)
      2'd1:    byte_v = hrdata[15:8];
      2'd2:    byte_v = hrdata[23:16];
      2'd3:    byte_v = hrdata[31:24];
      default: byte_v = hrdata[7:0];
    endcase
    half_v = addr[1] ? hrdata[31:16] : hrdata[15:0];

    case (size)
      HSIZE_B: rdata = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      HSIZE_H: rdata = {{16{~is_unsigned & half_v[15]}}, half_v};
      default: rdata = hrdata;
    endcase
  end

endmodule

// File: rtl/hazard1_lsu.sv
// rtl/hazard1_lsu.sv - Hazard1 load/store unit, one AHB-Lite access at a time
// Optional: HAZARD1_LSU_ALIGN_CHECK_EN rejects misaligned H/W accesses instead of aligning them.
module hazard1_lsu
  import hazard1_lsu_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [W_ADDR-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [W_DATA-1:0] hwdata,
  input  logic [W_DATA-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  lsu_state_e        state_q, state_d;
  logic [W_ADDR-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [W_DATA-1:0] hwdata_q, hwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [W_DATA-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              req_bad;
  logic [W_ADDR-1:0] addr_aligned;
  logic [W_DATA-1:0] wdata_lanes;
  logic [W_DATA-1:0] load_data;

  hazard1_lsu_extend u_extend (
    .hrdata      (hrdata),
    .addr        (haddr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (load_data)
  );

  always_comb begin
`ifdef HAZARD1_LSU_ALIGN_CHECK_EN
    req_bad = funct3_illegal(req_write, req_funct3) ||
              addr_misaligned(req_funct3[1:0], req_addr[1:0]);
`else
    req_bad = funct3_illegal(req_write, req_funct3);
`endif

    // When misalignment is rejected upstream this forcing is a no-op.
    case (req_funct3[1:0])
      HSIZE_H: addr_aligned = {req_addr[W_ADDR-1:1], 1'b0};
      HSIZE_W: addr_aligned = {req_addr[W_ADDR-1:2], 2'b00};
      default: addr_aligned = req_addr;
    endcase

    case (req_funct3[1:0])
      HSIZE_B: wdata_lanes = {4{req_wdata[7:0]}};
      HSIZE_H: wdata_lanes = {2{req_wdata[15:0]}};
      default: wdata_lanes = req_wdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = LSU_ADDR;
            htrans_d   = HTRANS_NONSEQ;
            haddr_d    = addr_aligned;
            hwrite_d   = req_write;
            size_d     = req_funct3[1:0];
            unsigned_d = req_funct3[2];
            hwdata_d   = wdata_lanes;
          end
        end
      end
      LSU_ADDR: begin
        if (hready) begin
          state_d  = LSU_DATA;
          htrans_d = HTRANS_IDLE;
        end
      end
      LSU_DATA: begin
        // An AHB error's first cycle has hready=0 and simply keeps us waiting.
        if (hready) begin
          state_d     = LSU_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = hresp;
          rsp_rdata_d = (!hwrite_q && !hresp) ? load_data : '0;
        end
      end
      default: begin
        state_d  = LSU_IDLE;
        htrans_d = HTRANS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == LSU_IDLE);
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = {1'b0, size_q};
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_hazard1_lsu.sv
// tb/tb_hazard1_lsu.sv - directed-vector bench for hazard1_lsu
module tb_hazard1_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int n_vec;
  int n_miss;

  hazard1_lsu #(.W_ADDR(32), .W_DATA(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hrdata     (hrdata),
    .hready     (hready),
    .hresp      (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where the response is visible.
  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rd,
                        input int dwait, input logic herr,
                        input logic [31:0] exp_haddr, input logic [31:0] exp_hwdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    hrdata     = rd;
    hready     = 1'b1;
    hresp      = 1'b0;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_htrans_a"}, {30'd0, htrans}, 32'd2);
    chk({tag, "_haddr"}, haddr, exp_haddr);
    chk({tag, "_hsize"}, {29'd0, hsize}, {30'd0, f3[1:0]});
    chk({tag, "_hwrite"}, {31'd0, hwrite}, {31'd0, wr});
    chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_rv_a"}, {31'd0, rsp_valid}, 32'd0);
    for (int i = 0; i <= dwait; i++) begin
      @(negedge clk);
      chk({tag, "_htrans_d"}, {30'd0, htrans}, 32'd0);
      chk({tag, "_rv_d"}, {31'd0, rsp_valid}, 32'd0);
      if (wr) chk({tag, "_hwdata"}, hwdata, exp_hwdata);
      hready = (i == dwait);
      hresp  = herr;
    end
    @(negedge clk);
    hready = 1'b1;
    hresp  = 1'b0;
    chk({tag, "_rv"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, "_ready_end"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic err_access(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = 32'h5555_aaaa;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_rv"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, rsp_err}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk({tag, "_rv_pulse"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_htrans2"}, {30'd0, htrans}, 32'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    hrdata     = 32'd0;
    hready     = 1'b1;
    hresp      = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_htrans", {30'd0, htrans}, 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
    chk("rst_hsize", {29'd0, hsize}, 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access("lw",  1'b0, 3'd2, 32'h1000, 32'd0, 32'hdeadbeef, 0, 1'b0, 32'h1000, 32'd0, 32'hdeadbeef, 1'b0);
    access("lb",  1'b0, 3'd0, 32'h1003, 32'd0, 32'h80123456, 0, 1'b0, 32'h1003, 32'd0, 32'hffffff80, 1'b0);
    access("lbu", 1'b0, 3'd4, 32'h1003, 32'd0, 32'h80123456, 0, 1'b0, 32'h1003, 32'd0, 32'h00000080, 1'b0);
    access("lb1", 1'b0, 3'd0, 32'h1001, 32'd0, 32'h80123456, 0, 1'b0, 32'h1001, 32'd0, 32'h00000034, 1'b0);
    access("lhu", 1'b0, 3'd5, 32'h1002, 32'd0, 32'h80123456, 0, 1'b0, 32'h1002, 32'd0, 32'h00008012, 1'b0);
    access("lh",  1'b0, 3'd1, 32'h1002, 32'd0, 32'h80123456, 0, 1'b0, 32'h1002, 32'd0, 32'hffff8012, 1'b0);
    access("lh0", 1'b0, 3'd1, 32'h1000, 32'd0, 32'h80127fff, 0, 1'b0, 32'h1000, 32'd0, 32'h00007fff, 1'b0);
    access("sb",  1'b1, 3'd0, 32'h2001, 32'h123456ab, 32'hffffffff, 2, 1'b0, 32'h2001, 32'habababab, 32'd0, 1'b0);
    access("sh",  1'b1, 3'd1, 32'h2002, 32'h1234cdef, 32'hffffffff, 0, 1'b0, 32'h2002, 32'hcdefcdef, 32'd0, 1'b0);
    access("sw",  1'b1, 3'd2, 32'h2004, 32'hcafef00d, 32'hffffffff, 1, 1'b0, 32'h2004, 32'hcafef00d, 32'd0, 1'b0);
    access("lwerr", 1'b0, 3'd2, 32'h3000, 32'd0, 32'h12345678, 1, 1'b1, 32'h3000, 32'd0, 32'd0, 1'b1);
    access("b2b", 1'b0, 3'd2, 32'h3004, 32'd0, 32'h0badf00d, 0, 1'b0, 32'h3004, 32'd0, 32'h0badf00d, 1'b0);

    err_access("ill_sz3", 1'b0, 3'd3, 32'h4000);
    err_access("ill_su",  1'b1, 3'd4, 32'h4000);

`ifdef HAZARD1_LSU_ALIGN_CHECK_EN
    err_access("mis_lw", 1'b0, 3'd2, 32'h1002);
    err_access("mis_sh", 1'b1, 3'd1, 32'h1001);
`else
    access("mis_lw", 1'b0, 3'd2, 32'h1002, 32'd0, 32'h11223344, 0, 1'b0, 32'h1000, 32'd0, 32'h11223344, 1'b0);
    access("mis_sh", 1'b1, 3'd1, 32'h1001, 32'h0000beef, 32'd0, 0, 1'b0, 32'h1000, 32'hbeefbeef, 32'd0, 1'b0);
`endif

    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h5000;
    hready     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    hready = 1'b0;
    @(negedge clk);
    chk("rstmid_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_htrans", {30'd0, htrans}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_rv", {31'd0, rsp_valid}, 32'd0);
    rst    = 1'b0;
    hready = 1'b1;
    @(negedge clk);
    chk("rstmid_rv2", {31'd0, rsp_valid}, 32'd0);
    chk("rstmid_ready2", {31'd0, req_ready}, 32'd1);

    access("post", 1'b0, 3'd2, 32'h6000, 32'd0, 32'h600d600d, 0, 1'b0, 32'h6000, 32'd0, 32'h600d600d, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
